// File: rtl/pb_debounce_dir.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, one-cycle Step per press, Dir toggle.
// Optional auto-repeat on long holds is enabled by defining PB_AUTOREPEAT_EN.
module pb_debounce_dir #(
    parameter int unsigned DbCycles     = 1_000_000,
    parameter int unsigned CntBits      = 27,
    parameter int unsigned HoldCycles   = 50_000_000,
    parameter int unsigned RepeatCycles = 25_000_000
) (
    input  logic Clk,
    input  logic Clr,
    input  logic PB,
    output logic Step,
    output logic Dir,
    output logic Pressed
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } state_t;

    localparam longint unsigned MaxCycles =
        (DbCycles > HoldCycles)
            ? ((longint'(DbCycles) > longint'(RepeatCycles)) ? longint'(DbCycles) : longint'(RepeatCycles))
            : ((longint'(HoldCycles) > longint'(RepeatCycles)) ? longint'(HoldCycles) : longint'(RepeatCycles));

    if ((DbCycles < 2) || ((CntBits < 63) && ((64'd1 << CntBits) <= MaxCycles))) begin : g_cfg_check
        $error("pb_debounce_dir: DbCycles must be >= 2 and 2**CntBits must exceed every cycle count");
    end

    localparam logic [CntBits-1:0] DbLast = CntBits'(DbCycles - 1);
    localparam logic [CntBits-1:0] CntOne = CntBits'(1);

    logic               s1_q;
    logic               s2_q;
    state_t             state_q;
    logic [CntBits-1:0] cnt_q;
    logic               step_q;
    logic               dir_q;
    logic               pressed_q;

`ifdef PB_AUTOREPEAT_EN
    localparam logic [CntBits-1:0] HoldLast = CntBits'(HoldCycles - 1);
    localparam logic [CntBits-1:0] RepLast  = CntBits'(RepeatCycles - 1);

    logic [CntBits-1:0] hold_q;
    logic               rep_q;
`endif

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= PB;
            s2_q <= s1_q;
        end
    end

    // The edge that sees s2 first change loads cnt with 1, so that stable
    // sample already counts and Step lands 2+DbCycles edges after PB moves.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            pressed_q <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
            hold_q    <= '0;
            rep_q     <= 1'b0;
`endif
        end else begin
            step_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pressed_q <= 1'b0;
                    cnt_q     <= '0;
                    if (s2_q) begin
                        state_q <= S_PRESS_WAIT;
                        cnt_q   <= CntOne;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!s2_q) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DbLast) begin
                        state_q   <= S_PRESSED;
                        cnt_q     <= '0;
                        step_q    <= 1'b1;
                        dir_q     <= ~dir_q;
                        pressed_q <= 1'b1;
`ifdef PB_AUTOREPEAT_EN
                        hold_q    <= '0;
                        rep_q     <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PRESSED: begin
                    pressed_q <= 1'b1;
                    if (!s2_q) begin
                        state_q <= S_RELEASE_WAIT;
                        cnt_q   <= CntOne;
                    end else begin
                        cnt_q <= '0;
`ifdef PB_AUTOREPEAT_EN
                        // Repeat pulses leave Dir alone; only accepted presses toggle it.
                        if ((!rep_q && hold_q == HoldLast) || (rep_q && hold_q == RepLast)) begin
                            step_q <= 1'b1;
                            hold_q <= '0;
                            rep_q  <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
`endif
                    end
                end
                S_RELEASE_WAIT: begin
                    pressed_q <= 1'b1;
                    if (s2_q) begin
                        state_q <= S_PRESSED;
                        cnt_q   <= '0;
`ifdef PB_AUTOREPEAT_EN
                        hold_q  <= '0;
                        rep_q   <= 1'b0;
`endif
                    end else if (cnt_q == DbLast) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        pressed_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign Step    = step_q;
    assign Dir     = dir_q;
    assign Pressed = pressed_q;

endmodule

// File: tb/tb_pb_debounce_dir.sv
// Directed bench for pb_debounce_dir with small cycle counts; covers auto-repeat when PB_AUTOREPEAT_EN is defined.
module tb_pb_debounce_dir;

    logic Clk;
    logic Clr;
    logic PB;
    logic Step;
    logic Dir;
    logic Pressed;

    int n_total;
    int n_pass;
    int steps;
    int low_cnt;
    int pos[8];

    pb_debounce_dir #(
        .DbCycles    (8),
        .CntBits     (8),
        .HoldCycles  (40),
        .RepeatCycles(16)
    ) dut (
        .Clk    (Clk),
        .Clr    (Clr),
        .PB     (PB),
        .Step   (Step),
        .Dir    (Dir),
        .Pressed(Pressed)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Advance n cycles, recording the tick index of each Step and cycles with Pressed low.
    task automatic watch(input int n);
        steps   = 0;
        low_cnt = 0;
        for (int i = 0; i < 8; i++) pos[i] = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (Step === 1'b1) begin
                if (steps < 8) pos[steps] = i;
                steps++;
            end
            if (Pressed !== 1'b1) low_cnt++;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        Clr     = 1'b0;
        PB      = 1'b0;

        // Reset held with PB toggling
        for (int i = 0; i < 10; i++) begin
            tick();
            PB = ~PB;
            chk("reset_outputs", {29'd0, Step, Pressed, Dir}, 1);
        end

        // Release reset with PB low: nothing changes
        PB  = 1'b0;
        Clr = 1'b1;
        watch(15);
        chk("idle_steps", steps, 0);
        chk("idle_pressed_low", low_cnt, 15);
        chk("idle_dir", Dir, 1);

        // Clean press, held 30 cycles
        PB = 1'b1;
        watch(30);
        chk("clean_steps", steps, 1);
        chk("clean_step_at", pos[0], 10);
        chk("clean_pressed_low", low_cnt, 9);
        chk("clean_dir", Dir, 0);
        PB = 1'b0;
        watch(9);
        chk("clean_rel_pressed_held", Pressed, 1);
        chk("clean_rel_steps", steps, 0);
        tick();
        chk("clean_rel_pressed_drop", Pressed, 0);
        watch(5);

        // Bouncy press: 3x (5 high, 2 low) then steady high
        for (int r = 0; r < 3; r++) begin
            PB = 1'b1;
            watch(5);
            chk("bounce_hi_steps", steps, 0);
            PB = 1'b0;
            watch(2);
            chk("bounce_lo_steps", steps, 0);
        end
        PB = 1'b1;
        watch(20);
        chk("bounce_steps", steps, 1);
        chk("bounce_step_at", pos[0], 10);
        chk("bounce_dir", Dir, 1);
        PB = 1'b0;
        watch(15);
        chk("bounce_rel_steps", steps, 0);
        chk("bounce_rel_pressed", Pressed, 0);

        // Release bounce while pressed
        PB = 1'b1;
        watch(12);
        chk("rb_press_steps", steps, 1);
        chk("rb_press_at", pos[0], 10);
        chk("rb_press_dir", Dir, 0);
        PB = 1'b0;
        watch(4);
        chk("rb_low_steps", steps, 0);
        chk("rb_low_pressed", low_cnt, 0);
        PB = 1'b1;
        watch(15);
        chk("rb_back_steps", steps, 0);
        chk("rb_back_pressed", low_cnt, 0);
        chk("rb_back_dir", Dir, 0);
        PB = 1'b0;
        watch(15);
        chk("rb_rel_steps", steps, 0);
        chk("rb_rel_pressed", Pressed, 0);

        // Reset in the middle of a press debounce
        PB = 1'b1;
        watch(6);
        chk("rst_mid_pre_steps", steps, 0);
        Clr = 1'b0;
        #1;
        chk("rst_mid_async", {29'd0, Step, Pressed, Dir}, 1);
        watch(3);
        chk("rst_mid_steps", steps, 0);
        chk("rst_mid_dir", Dir, 1);
        Clr = 1'b1;
        watch(15);
        chk("rst_rel_steps", steps, 1);
        chk("rst_rel_step_at", pos[0], 10);
        chk("rst_rel_dir", Dir, 0);
        PB = 1'b0;
        watch(15);
        chk("rst_rel_release_steps", steps, 0);

`ifdef PB_AUTOREPEAT_EN
        // Long hold: press step then hold and repeat steps; Dir toggles once
        PB = 1'b1;
        watch(100);
        chk("ar_steps", steps, 5);
        chk("ar_at0", pos[0], 10);
        chk("ar_at1", pos[1], 50);
        chk("ar_at2", pos[2], 66);
        chk("ar_at3", pos[3], 82);
        chk("ar_at4", pos[4], 98);
        chk("ar_dir", Dir, 1);
        PB = 1'b0;
        watch(15);
        chk("ar_rel_steps", steps, 0);
        chk("ar_rel_pressed", Pressed, 0);
`else
        // Long hold without auto-repeat: exactly one Step
        PB = 1'b1;
        watch(100);
        chk("hold_steps", steps, 1);
        chk("hold_step_at", pos[0], 10);
        chk("hold_dir", Dir, 1);
        PB = 1'b0;
        watch(15);
        chk("hold_rel_steps", steps, 0);
        chk("hold_rel_pressed", Pressed, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
